// File: rtl/data_sram_resp.sv
// Single-port 32-bit data memory with byte-enabled writes and 1-cycle read latency;
// clears itself after reset. Define DATA_SRAM_WFWD_EN for write-first read data.
module data_sram_resp #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CLR_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] CLR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_idx_q, clr_idx_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic                  init_done_q, init_done_d;
  logic [31:0]           mem_q [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] idx_s;
  logic                  accept_s;
  logic [31:0]           old_word_s;
  logic [3:0]            mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_widx_s;
  logic [31:0]           mem_wdata_s;
  logic                  unused_addr_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign idx_s         = data_sram_addr[ADDR_WIDTH+1:2];
  assign unused_addr_s = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};
  assign old_word_s    = mem_q[idx_s];

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clr_idx_q     <= '0;
      rdata_q       <= 32'h0000_0000;
      rdata_valid_q <= 1'b0;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      init_done_q   <= init_done_d;
    end
  end

  // Next-state: leave CLEAR once the last index has been written
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_idx_q == CLR_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Datapath: sweep writes, request writes and read-data capture
  always_comb begin
    clr_idx_d     = clr_idx_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    init_done_d   = (state_d == ST_READY);
    accept_s      = 1'b0;
    mem_we_s      = 4'b0000;
    mem_widx_s    = idx_s;
    mem_wdata_s   = data_sram_wdata;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d   = clr_idx_q + CLR_ONE;
        mem_we_s    = 4'b1111;
        mem_widx_s  = clr_idx_q[ADDR_WIDTH-1:0];
        mem_wdata_s = 32'h0000_0000;
      end
      ST_READY: begin
        accept_s = data_sram_en & init_done_q;
        if (accept_s) begin
          mem_we_s      = data_sram_we;
          rdata_valid_d = 1'b1;
`ifdef DATA_SRAM_WFWD_EN
          rdata_d = merge_bytes(old_word_s, data_sram_wdata, data_sram_we);
`else
          rdata_d = old_word_s;
`endif
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: begin
        mem_we_s = 4'b0000;
      end
    endcase
    if (reset) begin
      mem_we_s = 4'b0000;
    end else begin
      mem_we_s = mem_we_s;
    end
  end

  // Byte-lane array write port
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_s[i]) begin
        mem_q[mem_widx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign rdata_valid     = rdata_valid_q;
  assign init_done       = init_done_q;

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Single-port synchronous data memory that answers the load/store requests the EX stage drives on the `data_sram_*` interface. The memory side of the protocol:
- byte-enabled writes;
- read data returned exactly one cycle after the request, which is when the MEM stage samples it.

After reset it clears its whole array with an internal sweep before accepting requests. It replaces the vendor RAM in simulation and small-FPGA builds.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-index width. Depth is `2**ADDR_WIDTH` words of 32 bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_sram_en`  in  1  request valid this cycle.
- `data_sram_we`  in  4  byte write enables; bit i writes `wdata[8i+7:8i]`. `0000` means read.
- `data_sram_addr`  in  32  byte address.
- `data_sram_wdata`  in  32  write data, already lane-aligned by the initiator.
- `data_sram_rdata`  out  32  word read out, valid the cycle after the request.
- `rdata_valid`  out  1  high the cycle after an accepted request.
- `init_done`  out  1  high once the clear sweep has finished; requests are accepted only while high.

## Operation
Word index and address handling:
- Word index = `data_sram_addr[ADDR_WIDTH+1:2]`.
- `addr[1:0]` and the bits above `ADDR_WIDTH+1` are ignored, so high addresses alias onto the array.

State machine with two states, CLEAR and READY:
- **CLEAR** (entered on reset):
  - Sweep counter `clr_idx` starts at 0.
  - Each cycle writes 32'h0 to `mem[clr_idx]` and increments `clr_idx`.
  - After writing index `2**ADDR_WIDTH-1`, the next state is READY.
  - `data_sram_en` is ignored: no write, no `rdata_valid`.
- **READY**, accepted request = `data_sram_en & init_done`:
  - If `we != 0`: each enabled byte lane of `mem[idx]` is updated at the edge. Disabled lanes are unchanged.
  - Every accepted request, read or write, loads `data_sram_rdata` at the same edge with `mem[idx]` as it was *before* the write (read-first). The exception is when `DATA_SRAM_WFWD_EN` is defined; see Configuration.
  - `rdata_valid` is registered: high for one cycle after each accepted request.
- Hold behaviour:
  - `data_sram_rdata` holds its last value when there is no accepted request.
  - The MEM stage may sample it later than one cycle and still see the same value.
- Back-to-back requests are allowed every cycle. There is no backpressure and no ready signal.
- A write followed by a read of the same word on the next cycle returns the written data: the array has already been updated.

## Timing
Reset values, from the edge at which `reset` is sampled high:
- state = CLEAR, `clr_idx` = 0;
- `data_sram_rdata` = 32'h0;
- `rdata_valid` = 0;
- `init_done` = 0.

Clear sweep timing:
- With reset released at edge E0, the sweep writes indices 0..N-1 on edges E1..EN (N = `2**ADDR_WIDTH`).
- `init_done` rises after EN.
- The first request that can be accepted is the one presented in the cycle after EN.

Request latency:
- Request presented in cycle T → `data_sram_rdata` and `rdata_valid` valid in cycle T+1.
- Latency is fixed at 1.

Boundary conditions:
- `clr_idx` is `ADDR_WIDTH+1` bits wide, so terminal detection does not wrap.
- Reset asserted mid-sweep: the sweep restarts from index 0.
- Reset asserted in READY: the array is fully re-cleared. The state of an in-flight request is discarded: `rdata_valid` is 0 on the next cycle.
- `reset` takes priority over any request presented in the same cycle.

## Configuration
- `DATA_SRAM_WFWD_EN` defined (write-first): on an accepted write, `data_sram_rdata` at T+1 = merged word. Enabled lanes come from `wdata` and disabled lanes from the old `mem[idx]`.
- Not defined (default, read-first): `data_sram_rdata` at T+1 = the old `mem[idx]`.
- The macro does not affect array contents, read-only requests, latency or `rdata_valid`.

## Test plan
- **Reset/clear:** reset 1 cycle with `ADDR_WIDTH`=4 → `init_done` low for exactly 16 cycles, then high. Reads of 0x0, 0x3C and 0x40 (aliases to index 0) all return 0; a request with `en` held high during the sweep produces no `rdata_valid`.
- **Byte/half writes:**
  - write `we`=1111, 0x11223344 to 0x8;
  - then `we`=0010, wdata 0x0000AA00;
  - then `we`=1100, 0xBBCC0000;
  - read 0x8 → 0xBBCCAA44.
- **Back-to-back:** write 0xDEADBEEF to 0x10 in cycle T, read 0x10 in T+1 → `rdata` 0xDEADBEEF in T+2, `rdata_valid` high in T+1 and T+2.
- **Read-during-write:** `mem[5]` = 0x01020304; write `we`=0001, wdata 0xFF at 0x14.
  - Without the macro: `rdata` = 0x01020304.
  - With `DATA_SRAM_WFWD_EN`: `rdata` = 0x010203FF.
  - Both builds: a following read returns 0x010203FF.
- **Hold:** read 0x8 returning X, then `en`=0 for 5 cycles → `rdata` stays X and `rdata_valid` is 0 after the first cycle.
- **Reset mid-operation:** write 0x12345678 to 0x4, assert reset during a read request, then sweep → `rdata_valid` 0 the next cycle, `rdata` 0, and a read of 0x4 after `init_done` returns 0.
